lighthouse_emitter: RTL and testbench

- Synthetic lighthouse base-station transmitter that produces the photodiode pulse train a DarkRoom sensor input expects: per frame, one sync flash whose width encodes {skip, data, axis}, then one laser-sweep hit at a programmable delay.
- Axis alternates each frame.
- Drives one sensor_signal_i line of the DarkRoom decoder for bench and in-system loopback calibration without a physical base station.

---
 rtl/lighthouse_emitter.sv | 117 +++++++++++
 tb/tb_lighthouse_emitter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lighthouse_emitter.sv
// Synthetic lighthouse base station: per frame, one sync flash whose width encodes
// {skip, data_bit, axis}, then one sweep hit at a programmable delay; axis alternates.
module lighthouse_emitter #(
  parameter int CLK_PER_US   = 50,
  parameter int PERIOD_US    = 8333,
  parameter int SYNC_BASE_US = 63,
  parameter int SYNC_STEP_US = 10,
  parameter int SWEEP_US     = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [13:0] sweep_delay_x,
  input  logic [13:0] sweep_delay_y,
  input  logic        skip,
  input  logic        data_bit,
  output logic        sensor_o,
  output logic        axis_o,
  output logic        frame_start,
  output logic        busy
);

  localparam int PW = $clog2(CLK_PER_US);

  typedef enum logic [2:0] {IDLE, SYNC, GAP, SWEEP, TAIL} state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc;
  logic [13:0]   us_cnt;
  logic          enable_q;
  logic [14:0]   w_q, d_q, e_q;
  logic          sweep_en_q;

  logic          us_tick;
  logic [14:0]   us_next;
  logic          frame_end, frame_go, axis_new;
  logic [2:0]    code;
  logic [14:0]   w_calc, d_raw, d_calc, e_calc;
  logic          sweep_ok;

  assign us_tick   = (presc == PW'(CLK_PER_US - 1));
  assign us_next   = {1'b0, us_cnt} + 15'd1;
  assign frame_end = (state != IDLE) && us_tick && (us_next == 15'(PERIOD_US));
  // A frame restarts on its own end edge; from IDLE, enable registered one edge earlier starts it.
  assign frame_go  = (frame_end && enable) || ((state == IDLE) && enable_q);
  assign axis_new  = frame_end ? ~axis_o : axis_o;

  // Frame parameters are captured at frame start for the axis the new frame will carry.
  assign code     = {skip, data_bit, axis_new};
  assign w_calc   = 15'(SYNC_BASE_US) + 15'(SYNC_STEP_US) * {12'd0, code};
  assign d_raw    = axis_new ? {1'b0, sweep_delay_y} : {1'b0, sweep_delay_x};
  assign d_calc   = (d_raw < w_calc + 15'd1) ? w_calc + 15'd1 : d_raw;
  assign e_calc   = d_calc + 15'(SWEEP_US);
  assign sweep_ok = (e_calc <= 15'(PERIOD_US - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      presc      <= '0;
      us_cnt     <= '0;
      enable_q   <= 1'b0;
      axis_o     <= 1'b0;
      w_q        <= '0;
      d_q        <= '0;
      e_q        <= '0;
      sweep_en_q <= 1'b0;
    end else begin
      state    <= state_d;
      enable_q <= enable;
      if (frame_end)
        axis_o <= ~axis_o;
      if (frame_go) begin
        presc      <= '0;
        us_cnt     <= '0;
        w_q        <= w_calc;
        d_q        <= d_calc;
        e_q        <= e_calc;
        sweep_en_q <= sweep_ok;
      end else if (state != IDLE && !frame_end) begin
        presc <= us_tick ? '0 : presc + PW'(1);
        if (us_tick)
          us_cnt <= us_next[13:0];
      end else begin
        presc  <= '0;
        us_cnt <= '0;
      end
    end
  end

  // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state;
    if (frame_go) begin
      state_d = SYNC;
    end else if (frame_end) begin
      state_d = IDLE;
    end else begin
      case (state)
        SYNC:    if (us_tick && us_next == w_q) state_d = GAP;
        GAP: begin
          if (!sweep_en_q)                        state_d = TAIL;
          else if (us_tick && us_next == d_q)     state_d = SWEEP;
        end
        SWEEP:   if (us_tick && us_next == e_q) state_d = TAIL;
        default: state_d = state;
      endcase
    end
  end

  always_comb begin
    sensor_o    = (state == SYNC) || (state == SWEEP);
    busy        = (state != IDLE);
    frame_start = (state == SYNC) && (us_cnt == '0) && (presc == '0);
  end

endmodule

// File: tb/tb_lighthouse_emitter.sv
// Scoreboard bench for lighthouse_emitter: expected frame shapes are queued as frames
// are set up and compared against measurements taken from sensor_o / busy / frame_start.
module tb_lighthouse_emitter;

  localparam int C    = 2;
  localparam int P    = 400;
  localparam int BASE = 63;
  localparam int STEP = 10;
  localparam int SWP  = 10;
  localparam int LIM  = 2000;

  typedef struct {
    int axis;
    int sync_w;
    int rises;
    int sweep_off;
    int sweep_w;
    int len;
  } frame_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] sweep_delay_x = 14'd150;
  logic [13:0] sweep_delay_y = 14'd250;
  logic        skip = 1'b0;
  logic        data_bit = 1'b0;
  logic        sensor_o, axis_o, frame_start, busy;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  bit     model_axis = 1'b0;
  frame_t exp_q[$];

  lighthouse_emitter #(
    .CLK_PER_US(C), .PERIOD_US(P), .SYNC_BASE_US(BASE), .SYNC_STEP_US(STEP), .SWEEP_US(SWP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .sweep_delay_x(sweep_delay_x), .sweep_delay_y(sweep_delay_y),
    .skip(skip), .data_bit(data_bit),
    .sensor_o(sensor_o), .axis_o(axis_o), .frame_start(frame_start), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic frame_t model(bit s, bit d, bit a);
    frame_t f;
    int code, w, dd;
    code = (s ? 4 : 0) + (d ? 2 : 0) + (a ? 1 : 0);
    w    = BASE + STEP * code;
    dd   = a ? int'(sweep_delay_y) : int'(sweep_delay_x);
    if (dd < w + 1) dd = w + 1;
    f.axis   = a ? 1 : 0;
    f.sync_w = w * C;
    f.len    = P * C;
    if (dd + SWP > P - 1) begin
      f.rises = 0; f.sweep_off = -1; f.sweep_w = 0;
    end else begin
      f.rises = 1; f.sweep_off = dd * C; f.sweep_w = SWP * C;
    end
    return f;
  endfunction

  task automatic push(input bit s, input bit d);
    exp_q.push_back(model(s, d, model_axis));
    model_axis = ~model_axis;
  endtask

  // Monitor: measures each frame between frame_start strobes (or busy falling).
  int t_start, t_rise, sync_w, sweep_off, sweep_w, n_rises, n_falls, obs_axis;
  bit in_frame = 1'b0, prev_sensor = 1'b0, prev_busy = 1'b0;

  task automatic finalize(input int len);
    frame_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_frame", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("axis", obs_axis, e.axis);
    check("sync_width", sync_w, e.sync_w);
    check("sweep_count", n_rises, e.rises);
    check("sweep_offset", sweep_off, e.sweep_off);
    check("sweep_width", sweep_w, e.sweep_w);
    check("frame_len", len, e.len);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        in_frame = 1'b0; prev_sensor = 1'b0; prev_busy = 1'b0;
        continue;
      end
      if (frame_start) begin
        if (in_frame) finalize(cyc - t_start);
        in_frame = 1'b1; t_start = cyc; obs_axis = int'(axis_o);
        sync_w = -1; sweep_off = -1; sweep_w = 0; n_rises = 0; n_falls = 0;
      end else if (in_frame) begin
        if (sensor_o && !prev_sensor) begin
          n_rises++; sweep_off = cyc - t_start; t_rise = cyc;
        end
        if (!sensor_o && prev_sensor) begin
          if (n_falls == 0) sync_w = cyc - t_start;
          else              sweep_w = cyc - t_rise;
          n_falls++;
        end
        if (!busy && prev_busy) begin
          finalize(cyc - t_start);
          in_frame = 1'b0;
        end
      end
      prev_sensor = sensor_o;
      prev_busy   = busy;
    end
  end

  // Returns the number of rising edges until frame_start is seen, or -1 on timeout.
  task automatic wait_start(output int lat);
    lat = -1;
    for (int i = 1; i <= LIM; i++) begin
      @(negedge clock);
      if (frame_start) begin
        lat = i;
        return;
      end
    end
    check("start_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < LIM; i++) begin
      @(negedge clock);
      if (!busy) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  // Runs n back-to-back frames; frame k uses {skip,data_bit} = seq[2k+1:2k].
  task automatic run_frames(input int n, input logic [15:0] seq);
    int lat;
    {skip, data_bit} = seq[1:0];
    push(seq[1], seq[0]);
    enable = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_start(lat);
      if (lat < 0) return;
      if (k == 0) check("start_latency", lat, 2);
      if (k < n - 1) begin
        {skip, data_bit} = seq[2*k+2 +: 2];
        push(seq[2*k+3], seq[2*k+2]);
      end else begin
        enable = 1'b0;
      end
    end
    wait_idle();
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clock);
    check("rst_sensor", int'(sensor_o), 0);
    check("rst_axis", int'(axis_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_start", int'(frame_start), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Basic pair of frames, then all eight sync codes.
    run_frames(2, 16'h0000);
    run_frames(8, {2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00});

    // Delay shorter than the sync: sweep clamped to W+1.
    sweep_delay_x = 14'd10;
    run_frames(2, 16'h000F);

    // Delay too late for the sweep to fit in the frame: no sweep on axis 0.
    sweep_delay_x = 14'd395;
    run_frames(2, 16'h0000);
    sweep_delay_x = 14'd150;

    // Enable dropped 100 us into a frame: frame completes, then idles.
    {skip, data_bit} = 2'b00;
    push(1'b0, 1'b0);
    enable = 1'b1;
    wait_start(lat);
    repeat (2 * 100) @(negedge clock);
    enable = 1'b0;
    check("busy_after_disable", int'(busy), 1);
    wait_idle();
    repeat (5) @(negedge clock);
    check("idle_sensor", int'(sensor_o), 0);
    check("idle_busy", int'(busy), 0);

    // Re-enable: starts two edges later with the toggled axis, then reset inside the sweep.
    push(1'b0, 1'b0);
    enable = 1'b1;
    wait_start(lat);
    check("reenable_latency", lat, 2);
    check("reenable_axis", int'(axis_o), 1);
    repeat (2 * 255) @(negedge clock);
    check("in_sweep", int'(sensor_o), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sensor", int'(sensor_o), 0);
    check("arst_axis", int'(axis_o), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_frame_start", int'(frame_start), 0);
    exp_q.delete();
    model_axis = 1'b0;
    push(1'b0, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wait_start(lat);
    check("post_reset_latency", lat, 2);
    check("post_reset_axis", int'(axis_o), 0);
    check("post_reset_strobe", int'(frame_start), 1);
    enable = 1'b0;
    wait_idle();
    repeat (3) @(negedge clock);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
